// File: rtl/msx_esp_uart_bridge_pkg.sv
//------------------------------------------------------------------------------
// msx_esp_uart_bridge_pkg : shared types and constants for the MSX/ESP bridge
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package msx_esp_uart_bridge_pkg;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  localparam int STAT_RX_AVAIL = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_OVERRUN  = 2;
  localparam int STAT_TX_BUSY  = 3;
  localparam int STAT_FERR     = 4;

  // Bit period in clock cycles, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/msx_esp_uart_bridge_sync_fifo.sv
//------------------------------------------------------------------------------
// bridge_sync_fifo : single-clock FIFO with flush, used for the TX and RX paths
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bridge_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/msx_esp_uart_bridge.sv
//------------------------------------------------------------------------------
// msx_esp_uart_bridge : MSX I/O ports <-> ESP8266 8N1 UART with TX/RX FIFOs
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module msx_esp_uart_bridge
  import msx_esp_uart_bridge_pkg::*;
#(
  parameter int         CLK_HZ      = 50000000,
  parameter int         BAUD        = 115200,
  parameter logic [7:0] DATA_PORT   = 8'h06,
  parameter logic [7:0] STATUS_PORT = 8'h07,
  parameter int         FIFO_DEPTH  = 16
) (
  input  logic       clk50m,
  input  logic       rst,
  input  logic       msx_iorq,
  input  logic       msx_rd,
  input  logic       msx_wr,
  input  logic [7:0] msx_adr,
  input  logic [7:0] msx_data_in,
  output logic [7:0] msx_data_out,
  output logic       msx_data_oe,
  input  logic       esp_rxd,
  output logic       esp_txd
);

  localparam int                BIT_CYC   = baud_div(CLK_HZ, BAUD);
  localparam int                CNT_W     = $clog2(BIT_CYC + 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(BIT_CYC / 2 - 1);

  logic [1:0] iorq_sr, rd_sr, wr_sr, rxd_sr;
  logic       wr_act, rd_act, wr_act_q, rd_act_q, rxd_s, rxd_q;
  logic       wr_rise, rd_rise, rd_fall;
  logic [7:0] rd_adr;

  always_ff @(posedge clk50m) begin
    if (rst) begin
      iorq_sr  <= 2'b11;
      rd_sr    <= 2'b11;
      wr_sr    <= 2'b11;
      rxd_sr   <= 2'b11;
      wr_act_q <= 1'b0;
      rd_act_q <= 1'b0;
      rxd_q    <= 1'b1;
      rd_adr   <= 8'h00;
    end else begin
      iorq_sr  <= {iorq_sr[0], msx_iorq};
      rd_sr    <= {rd_sr[0], msx_rd};
      wr_sr    <= {wr_sr[0], msx_wr};
      rxd_sr   <= {rxd_sr[0], esp_rxd};
      wr_act_q <= wr_act;
      rd_act_q <= rd_act;
      rxd_q    <= rxd_s;
      // The bus address is gone by the time the synchronised read ends.
      if (rd_rise) rd_adr <= msx_adr;
    end
  end

  assign wr_act  = !iorq_sr[1] && !wr_sr[1];
  assign rd_act  = !iorq_sr[1] && !rd_sr[1];
  assign rxd_s   = rxd_sr[1];
  assign wr_rise = wr_act && !wr_act_q;
  assign rd_rise = rd_act && !rd_act_q;
  assign rd_fall = !rd_act && rd_act_q;

  logic       wr_stat, tx_push, tx_flush, rx_flush, rx_pop, flag_clr;
  logic       tx_pop, tx_full, tx_empty, rx_push, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head, rx_shift;

  assign wr_stat  = wr_rise && (msx_adr == STATUS_PORT);
  assign tx_push  = wr_rise && (msx_adr == DATA_PORT);
  assign tx_flush = wr_stat && msx_data_in[1];
  assign rx_flush = wr_stat && msx_data_in[0];
  assign rx_pop   = rd_fall && (rd_adr == DATA_PORT);
  assign flag_clr = (wr_stat && msx_data_in[2]) || (rd_fall && (rd_adr == STATUS_PORT));

  bridge_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk50m), .rst(rst), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .din(msx_data_in), .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  bridge_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(clk50m), .rst(rst), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
    .din(rx_shift), .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  uart_state_t      tx_state, tx_next;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic             tx_tick, tx_avail;

  assign tx_tick  = (tx_cnt == BIT_LAST);
  assign tx_avail = !tx_empty && !tx_flush;

  always_ff @(posedge clk50m) begin
    if (rst) tx_state <= UART_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      UART_IDLE:  if (tx_avail) tx_next = UART_START;
      UART_START: if (tx_tick) tx_next = UART_DATA;
      UART_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = UART_STOP;
      UART_STOP:  if (tx_tick) tx_next = tx_avail ? UART_START : UART_IDLE;
      default:    tx_next = UART_IDLE;
    endcase
  end

  always_comb begin
    esp_txd = 1'b1;
    tx_pop  = 1'b0;
    case (tx_state)
      UART_IDLE:  tx_pop  = tx_avail;
      UART_START: esp_txd = 1'b0;
      UART_DATA:  esp_txd = tx_shift[0];
      UART_STOP:  tx_pop  = tx_tick && tx_avail;
      default:    esp_txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
    end else begin
      if (tx_state == UART_IDLE || tx_tick) tx_cnt <= '0;
      else                                  tx_cnt <= tx_cnt + 1'b1;
      if (tx_pop) begin
        tx_shift <= tx_head;
        tx_bit   <= 3'd0;
      end else if (tx_state == UART_DATA && tx_tick) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_bit   <= tx_bit + 1'b1;
      end
    end
  end

  uart_state_t      rx_state, rx_next;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic             rx_tick, rx_half, rx_fall, ovr_set, ferr_set;
  logic             overrun, ferr;

  assign rx_tick = (rx_cnt == BIT_LAST);
  assign rx_half = (rx_cnt == HALF_LAST);
  // Needs a high-to-low transition, so after a framing error the line must idle high first.
  assign rx_fall = rxd_q && !rxd_s;

  always_ff @(posedge clk50m) begin
    if (rst) rx_state <= UART_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      UART_IDLE:  if (rx_fall) rx_next = UART_START;
      UART_START: if (rx_half) rx_next = rxd_s ? UART_IDLE : UART_DATA;
      UART_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = UART_STOP;
      UART_STOP:  if (rx_tick) rx_next = UART_IDLE;
      default:    rx_next = UART_IDLE;
    endcase
  end

  always_comb begin
    rx_push  = 1'b0;
    ovr_set  = 1'b0;
    ferr_set = 1'b0;
    if (rx_state == UART_STOP && rx_tick) begin
      rx_push  = rxd_s;
      ovr_set  = rxd_s && rx_full && !rx_pop;
      ferr_set = !rxd_s;
    end
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
      overrun  <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      if (rx_state == UART_IDLE || rx_tick || (rx_state == UART_START && rx_half)) rx_cnt <= '0;
      else                                                                        rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == UART_START) begin
        rx_bit <= 3'd0;
      end else if (rx_state == UART_DATA && rx_tick) begin
        rx_shift <= {rxd_s, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
      if (ovr_set)       overrun <= 1'b1;
      else if (flag_clr) overrun <= 1'b0;
      if (ferr_set)      ferr    <= 1'b1;
      else if (flag_clr) ferr    <= 1'b0;
    end
  end

  logic [7:0] status;

  always_comb begin
    status                = 8'h00;
    status[STAT_RX_AVAIL] = !rx_empty;
    status[STAT_TX_FULL]  = tx_full;
    status[STAT_OVERRUN]  = overrun;
    status[STAT_TX_BUSY]  = (tx_state != UART_IDLE) || !tx_empty;
    status[STAT_FERR]     = ferr;
  end

  assign msx_data_oe  = !msx_iorq && !msx_rd && ((msx_adr == DATA_PORT) || (msx_adr == STATUS_PORT));
  assign msx_data_out = (msx_adr == STATUS_PORT) ? status : (rx_empty ? 8'hFF : rx_head);

endmodule

`default_nettype wire

// File: tb/tb_msx_esp_uart_bridge.sv
//------------------------------------------------------------------------------
// tb_msx_esp_uart_bridge : self-checking bench for the MSX/ESP UART bridge
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_msx_esp_uart_bridge;

  // 50 MHz / 1.152 Mbaud rounds to 43 cycles per bit, keeping the run short.
  localparam int B = 43;

  logic       clk50m = 1'b0;
  logic       rst = 1'b1;
  logic       msx_iorq = 1'b1, msx_rd = 1'b1, msx_wr = 1'b1;
  logic [7:0] msx_adr = 8'h00, msx_data_in = 8'h00;
  logic [7:0] msx_data_out;
  logic       msx_data_oe;
  logic       esp_rxd = 1'b1;
  logic       esp_txd;

  always #10 clk50m = ~clk50m;

  msx_esp_uart_bridge #(
    .CLK_HZ(50000000), .BAUD(1152000), .DATA_PORT(8'h06), .STATUS_PORT(8'h07), .FIFO_DEPTH(16)
  ) dut (
    .clk50m(clk50m), .rst(rst), .msx_iorq(msx_iorq), .msx_rd(msx_rd), .msx_wr(msx_wr),
    .msx_adr(msx_adr), .msx_data_in(msx_data_in), .msx_data_out(msx_data_out),
    .msx_data_oe(msx_data_oe), .esp_rxd(esp_rxd), .esp_txd(esp_txd)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  int         tx_frames = 0;
  bit         tx_abort = 1'b0;
  logic [7:0] sb_tx[$];
  logic [7:0] sb_rx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Serial monitor: captures each esp_txd frame, checks bit windows, compares to scoreboard.
  logic       smp [10*B];
  logic       mon_ok, mon_abort;
  logic [7:0] mon_byte;

  always begin : tx_monitor
    @(negedge clk50m);
    if (!tx_abort && esp_txd == 1'b0) begin
      mon_abort = 1'b0;
      for (int c = 0; c < 10*B; c++) begin
        if (c > 0) @(negedge clk50m);
        if (tx_abort) begin
          mon_abort = 1'b1;
          break;
        end
        smp[c] = esp_txd;
      end
      if (!mon_abort) begin
        mon_ok = 1'b1;
        for (int k = 0; k < 10; k++)
          for (int p = 1; p <= B-2; p++)
            if (smp[k*B+p] !== smp[k*B+B/2]) mon_ok = 1'b0;
        if (smp[B/2] !== 1'b0 || smp[9*B+B/2] !== 1'b1) mon_ok = 1'b0;
        for (int k = 0; k < 8; k++) mon_byte[k] = smp[(k+1)*B+B/2];
        tx_frames++;
        check("tx_frame_shape", {31'd0, mon_ok}, 32'd1);
        if (sb_tx.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_unexpected_frame: actual 0x%0h required no frame", mon_byte);
        end else begin
          check("tx_byte", {24'd0, mon_byte}, {24'd0, sb_tx.pop_front()});
        end
      end
    end
  end

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk50m);
    msx_adr = a; msx_data_in = d; msx_iorq = 1'b0; msx_wr = 1'b0;
    repeat (4) @(negedge clk50m);
    msx_iorq = 1'b1; msx_wr = 1'b1; msx_adr = 8'h00; msx_data_in = 8'h00;
    repeat (6) @(negedge clk50m);
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d, output logic oe);
    @(negedge clk50m);
    msx_adr = a; msx_iorq = 1'b0; msx_rd = 1'b0;
    repeat (4) @(negedge clk50m);
    d = msx_data_out; oe = msx_data_oe;
    msx_iorq = 1'b1; msx_rd = 1'b1; msx_adr = 8'h00;
    repeat (6) @(negedge clk50m);
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    logic       oe;
    io_read(a, d, oe);
    check(name, {24'd0, d}, {24'd0, exp});
    check("read_oe", {31'd0, oe}, 32'd1);
  endtask

  task automatic esp_send(input logic [7:0] b, input logic stop_bit);
    @(negedge clk50m);
    esp_rxd = 1'b0;
    repeat (B) @(negedge clk50m);
    for (int i = 0; i < 8; i++) begin
      esp_rxd = b[i];
      repeat (B) @(negedge clk50m);
    end
    esp_rxd = stop_bit;
    repeat (B) @(negedge clk50m);
    esp_rxd = 1'b1;
    repeat (B) @(negedge clk50m);
  endtask

  typedef struct {
    logic [7:0] rx_byte;
    logic       stop_bit;
    logic [7:0] exp_status;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic [7:0] d;
    logic       oe;
    int         f0;

    vecs[0] = '{8'h3C, 1'b1, 8'h01, 8'h3C};
    vecs[1] = '{8'h00, 1'b1, 8'h01, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 8'h01, 8'hFF};
    vecs[3] = '{8'h55, 1'b0, 8'h10, 8'hFF};
    vecs[4] = '{8'h11, 1'b1, 8'h01, 8'h11};
    vecs[5] = '{8'h80, 1'b1, 8'h01, 8'h80};
    vecs[6] = '{8'hA1, 1'b1, 8'h01, 8'hA1};

    repeat (5) @(negedge clk50m);
    rst = 1'b0;
    repeat (3) @(negedge clk50m);

    // Reset / idle state
    check("reset_txd", {31'd0, esp_txd}, 32'd1);
    check("reset_oe", {31'd0, msx_data_oe}, 32'd0);
    read_check("reset_status", 8'h07, 8'h00);
    read_check("empty_data", 8'h06, 8'hFF);
    read_check("status_after_empty_read", 8'h07, 8'h00);
    io_read(8'h08, d, oe);
    check("other_port_oe", {31'd0, oe}, 32'd0);

    // Single TX frame, busy during and idle after
    f0 = tx_frames;
    sb_tx.push_back(8'hA5);
    io_write(8'h06, 8'hA5);
    read_check("tx_busy_status", 8'h07, 8'h08);
    repeat (12*B) @(negedge clk50m);
    read_check("tx_done_status", 8'h07, 8'h00);
    check("tx_single_frames", tx_frames - f0, 32'd1);

    // Table-driven RX vectors, including a framing error
    foreach (vecs[i]) begin
      esp_send(vecs[i].rx_byte, vecs[i].stop_bit);
      read_check("vec_status", 8'h07, vecs[i].exp_status);
      read_check("vec_data", 8'h06, vecs[i].exp_data);
      read_check("vec_status_after", 8'h07, 8'h00);
    end

    // RX overrun: 17 bytes, the 17th dropped
    for (int i = 0; i < 17; i++) begin
      esp_send(8'(i * 13 + 7), 1'b1);
      if (i < 16) sb_rx.push_back(8'(i * 13 + 7));
    end
    read_check("overrun_status", 8'h07, 8'h05);
    read_check("overrun_cleared", 8'h07, 8'h01);
    while (sb_rx.size() > 0) read_check("rx_fifo_data", 8'h06, sb_rx.pop_front());
    read_check("rx_drained_data", 8'h06, 8'hFF);
    read_check("rx_drained_status", 8'h07, 8'h00);

    // RX flush via status write
    esp_send(8'h42, 1'b1);
    read_check("pre_flush_status", 8'h07, 8'h01);
    io_write(8'h07, 8'h01);
    read_check("rx_flushed_status", 8'h07, 8'h00);

    // TX burst of 18: one in flight + 16 buffered, 18th dropped
    f0 = tx_frames;
    for (int i = 0; i < 18; i++) begin
      if (i < 17) sb_tx.push_back(8'(8'hC0 + i));
      io_write(8'h06, 8'(8'hC0 + i));
    end
    read_check("tx_full_status", 8'h07, 8'h0A);
    repeat (18*10*B) @(negedge clk50m);
    check("tx_burst_frames", tx_frames - f0, 32'd17);
    check("tx_burst_sb_empty", sb_tx.size(), 32'd0);
    read_check("tx_burst_idle", 8'h07, 8'h00);

    // TX flush mid-stream: only the frame in flight completes
    f0 = tx_frames;
    sb_tx.push_back(8'h31);
    for (int i = 0; i < 5; i++) io_write(8'h06, 8'(8'h31 + i));
    io_write(8'h07, 8'h02);
    repeat (4*10*B) @(negedge clk50m);
    check("tx_flush_frames", tx_frames - f0, 32'd1);
    read_check("tx_flush_idle", 8'h07, 8'h00);

    // Reset mid-frame truncates the transfer
    f0 = tx_frames;
    io_write(8'h06, 8'h96);
    repeat (3*B) @(negedge clk50m);
    tx_abort = 1'b1;
    @(negedge clk50m);
    rst = 1'b1;
    @(negedge clk50m);
    rst = 1'b0;
    check("reset_midframe_txd", {31'd0, esp_txd}, 32'd1);
    repeat (2*10*B) @(negedge clk50m);
    tx_abort = 1'b0;
    check("reset_midframe_frames", tx_frames - f0, 32'd0);
    read_check("reset_midframe_status", 8'h07, 8'h00);
    check("final_tx_sb_empty", sb_tx.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
